masked_chi_pipe: RTL and testbench

- Three-share masked Chi layer with no fresh randomness, parametrised in row width and parallel lane count.
- Adds valid/ready flow control, back-pressure stalls, a per-transaction mode (Chi or share-preserving pass-through) and a synchronous flush.
- Sits between the linear layers and the state register of masked Keccak/Xoodoo-style permutation datapaths.
- The nonlinear stage is register-separated from share compression, so no glitch path ever combines shares of the same input variable.

---
 rtl/masked_chi_pkg.sv | 15 +
 rtl/masked_chi_cf.sv | 21 ++
 rtl/masked_chi_pipe.sv | 111 +++++++++++
 tb/tb_masked_chi_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_chi_pkg.sv
// masked_chi_pkg: shared constants, mode encoding and index helper for the masked Chi pipeline.
package masked_chi_pkg;

    localparam int NSHARES = 3;

    typedef enum logic {
        CHI_MODE_CHI  = 1'b0,
        CHI_MODE_PASS = 1'b1
    } chi_mode_e;

    function automatic int idx_mod(input int i, input int width);
        return i % width;
    endfunction

endpackage

// File: rtl/masked_chi_cf.sv
// masked_chi_cf: the nine component functions of one Chi bit across three shares.
// Each output touches at most one share of each of a[i], a[i+1], a[i+2].
module masked_chi_cf
    import masked_chi_pkg::*;
(
    input  logic [NSHARES-1:0]         a_i,
    input  logic [NSHARES-1:0]         x_i,
    input  logic [NSHARES-1:0]         y_i,
    input  chi_mode_e                  mode_i,
    output logic [NSHARES*NSHARES-1:0] cf_o
);

    always_comb begin
        cf_o = '0;
        for (int s = 0; s < NSHARES; s++)
            for (int k = 0; k < NSHARES; k++)
                cf_o[NSHARES*s+k] = (mode_i == CHI_MODE_PASS) ? ((s == k) & a_i[s])
                                  : ((x_i[s] & y_i[k]) ^ ((s == k) & (a_i[s] ^ y_i[s])));
    end

endmodule

// File: rtl/masked_chi_pipe.sv
// masked_chi_pipe: three-share Chi layer, registered component functions then share compression.
// MASKED_CHI_OUT_REG_EN adds a registered output share stage (latency 2 instead of 1).
module masked_chi_pipe
    import masked_chi_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   in_mode_i,
    input  logic [LANES*WIDTH-1:0] in1_i,
    input  logic [LANES*WIDTH-1:0] in2_i,
    input  logic [LANES*WIDTH-1:0] in3_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES*WIDTH-1:0] out1_o,
    output logic [LANES*WIDTH-1:0] out2_o,
    output logic [LANES*WIDTH-1:0] out3_o
);

    localparam int N = LANES * WIDTH;

    if (WIDTH < 3) begin : g_width_check
        $error("masked_chi_pipe: WIDTH must be >= 3");
    end

    logic [9*N-1:0] cf_comb, cf_d, cf_q;
    logic           s1_valid_d, s1_valid_q;
    logic           ready_s2, in_acc;
    logic [N-1:0]   comp1, comp2, comp3;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            localparam int J  = l*WIDTH + i;
            localparam int JX = l*WIDTH + idx_mod(i + 1, WIDTH);
            localparam int JY = l*WIDTH + idx_mod(i + 2, WIDTH);
            masked_chi_cf u_cf (
                .a_i    ({in3_i[J],  in2_i[J],  in1_i[J]}),
                .x_i    ({in3_i[JX], in2_i[JX], in1_i[JX]}),
                .y_i    ({in3_i[JY], in2_i[JY], in1_i[JY]}),
                .mode_i (chi_mode_e'(in_mode_i)),
                .cf_o   (cf_comb[9*J +: 9])
            );
            // Compression reads only registered cf, never the live inputs.
            assign comp1[J] = ^cf_q[9*J     +: 3];
            assign comp2[J] = ^cf_q[9*J + 3 +: 3];
            assign comp3[J] = ^cf_q[9*J + 6 +: 3];
        end
    end

    always_comb begin
        in_ready_o = !flush_i && (!s1_valid_q || ready_s2);
        in_acc     = in_valid_i && in_ready_o;
        s1_valid_d = !flush_i && (in_acc || (s1_valid_q && !ready_s2));
        cf_d       = in_acc ? cf_comb : cf_q;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            cf_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            cf_q       <= cf_d;
        end
    end

`ifdef MASKED_CHI_OUT_REG_EN
    logic         out_valid_d, out_valid_q, s2_load;
    logic [N-1:0] o1_d, o1_q, o2_d, o2_q, o3_d, o3_q;

    always_comb begin
        ready_s2    = !out_valid_q || out_ready_i;
        s2_load     = s1_valid_q && ready_s2 && !flush_i;
        out_valid_d = !flush_i && (s2_load || (out_valid_q && !out_ready_i));
        o1_d        = s2_load ? comp1 : o1_q;
        o2_d        = s2_load ? comp2 : o2_q;
        o3_d        = s2_load ? comp3 : o3_q;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            o1_q        <= '0;
            o2_q        <= '0;
            o3_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            o1_q        <= o1_d;
            o2_q        <= o2_d;
            o3_q        <= o3_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out1_o      = o1_q;
    assign out2_o      = o2_q;
    assign out3_o      = o3_q;
`else
    assign ready_s2    = out_ready_i;
    assign out_valid_o = s1_valid_q;
    assign out1_o      = comp1;
    assign out2_o      = comp2;
    assign out3_o      = comp3;
`endif

endmodule

// File: tb/tb_masked_chi_pipe.sv
// tb_masked_chi_pipe: directed and randomized checks of masked_chi_pipe against a share-level Chi model.
// Honours MASKED_CHI_OUT_REG_EN for the expected latency.
module tb_masked_chi_pipe;

    localparam int W = 5;
    localparam int L = 2;
    localparam int N = W * L;
`ifdef MASKED_CHI_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 0, rst_i = 0, flush_i = 0, in_valid_i = 0, in_mode_i = 0, out_ready_i = 1;
    logic [N-1:0] in1_i = '0, in2_i = '0, in3_i = '0;
    logic         in_ready_o, out_valid_o;
    logic [N-1:0] out1_o, out2_o, out3_o;

    masked_chi_pipe #(.WIDTH(W), .LANES(L)) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_mode_i   (in_mode_i),
        .in1_i       (in1_i),
        .in2_i       (in2_i),
        .in3_i       (in3_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out1_o      (out1_o),
        .out2_o      (out2_o),
        .out3_o      (out3_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] o1, o2, o3;
        int           e;
    } ent_t;

    ent_t q[$];
    int   checks = 0, failures = 0, edges = 0, ndeliv = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [N-1:0] rot(input logic [N-1:0] v, input int r);
        logic [N-1:0] o;
        for (int l = 0; l < L; l++)
            for (int i = 0; i < W; i++)
                o[l*W+i] = v[l*W + (i + r) % W];
        return o;
    endfunction

    // Share s of Chi: a_s ^ a_s[i+2] ^ (a_s[i+1] & a[i+2]), a = unmasked value.
    function automatic ent_t model(input logic m, input logic [N-1:0] a1, a2, a3, input int e);
        ent_t         r;
        logic [N-1:0] y;
        y    = rot(a1 ^ a2 ^ a3, 2);
        r.o1 = m ? a1 : a1 ^ rot(a1, 2) ^ (rot(a1, 1) & y);
        r.o2 = m ? a2 : a2 ^ rot(a2, 2) ^ (rot(a2, 1) & y);
        r.o3 = m ? a3 : a3 ^ rot(a3, 2) ^ (rot(a3, 1) & y);
        r.e  = e;
        return r;
    endfunction

    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin : cmp
        logic ev;
        if (rst_i) q.delete();
        else begin
            ev = 1'b0;
            if (q.size() > 0) ev = (q[0].e + LAT - 1 <= edges);
            chk("out_valid", out_valid_o, ev);
            chk("in_ready", in_ready_o, !flush_i && (q.size() < LAT || out_ready_i));
            if (out_valid_o && q.size() > 0) begin
                chk("out1", out1_o, q[0].o1);
                chk("out2", out2_o, q[0].o2);
                chk("out3", out3_o, q[0].o3);
                if (out_ready_i) begin
                    void'(q.pop_front());
                    ndeliv++;
                end
            end
            if (flush_i) q.delete();
            else if (in_valid_i && in_ready_o)
                q.push_back(model(in_mode_i, in1_i, in2_i, in3_i, edges + 1));
        end
    end

    task automatic send(input logic m, input logic [N-1:0] a1, a2, a3);
        int t = 0;
        in_mode_i  = m;
        in1_i      = a1;
        in2_i      = a2;
        in3_i      = a3;
        in_valid_i = 1;
        @(negedge clk);
        while (!in_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", in_ready_o, 1);
        @(posedge clk);
        #1 in_valid_i = 0;
    endtask

    task automatic wait_out(output logic [N-1:0] x, output logic [N-1:0] s1);
        int t = 0;
        @(negedge clk);
        while (!out_valid_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("out_seen", out_valid_o, 1);
        x  = out1_o ^ out2_o ^ out3_o;
        s1 = out1_o;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid_i  = 0;
        out_ready_i = 1;
        repeat (LAT + 3) @(posedge clk);
        #1 chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        ent_t         m;
        logic [N-1:0] x, s1, r1, r2;
        int           nb, idx;
        #1 rst_i = 1;
        #2;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_out1", out1_o, 0);
        chk("rst_out2", out2_o, 0);
        chk("rst_out3", out3_o, 0);
        chk("rst_ready", in_ready_o, 1);
        repeat (2) @(posedge clk);
        #1 rst_i = 0;
        @(posedge clk);
        #1;

        m = model(0, {L{5'b10110}}, '0, '0, 0);
        chk("model_pin", m.o1 ^ m.o2 ^ m.o3, {L{5'b00010}});

        send(0, {L{5'b10110}}, '0, '0);
        wait_out(x, s1);
        chk("chi_plain", x, {L{5'b00010}});

        send(0, {L{5'b01101}}, {L{5'b11000}}, {L{5'b00011}});
        wait_out(x, s1);
        chk("chi_masked", x, {L{5'b00010}});

        r1 = N'($urandom);
        r2 = N'($urandom);
        send(0, r1, r2, r1 ^ r2);
        wait_out(x, s1);
        chk("chi_zero", x, '0);

        send(0, r1, r2, ~(r1 ^ r2));
        wait_out(x, s1);
        chk("chi_ones", x, {N{1'b1}});

        send(1, {L{5'h0A}}, {L{5'h13}}, {L{5'h1C}});
        wait_out(x, s1);
        chk("pass_xor", x, {L{5'h0A ^ 5'h13 ^ 5'h1C}});
        chk("pass_s1", s1, {L{5'h0A}});

        nb  = ndeliv;
        idx = 0;
        for (int t = 0; t < 12; t++) begin
            out_ready_i = !(t >= 2 && t < 5);
            in_valid_i  = idx < 4;
            in_mode_i   = 0;
            in1_i       = N'($urandom);
            in2_i       = N'($urandom);
            in3_i       = N'($urandom);
            @(negedge clk);
            if (t == 4) chk("bp_ready_full", in_ready_o, 0);
            if (in_valid_i && in_ready_o) idx++;
            @(posedge clk);
            #1;
        end
        drain();
        chk("bp_delivered", ndeliv - nb, 4);

        out_ready_i = 0;
        send(0, N'($urandom), N'($urandom), N'($urandom));
        repeat (2) @(posedge clk);
        #1 flush_i = 1;
        @(negedge clk);
        chk("flush_pre_valid", out_valid_o, 1);
        chk("flush_ready", in_ready_o, 0);
        @(posedge clk);
        #1 flush_i = 0;
        chk("flush_valid", out_valid_o, 0);
        out_ready_i = 1;
        @(posedge clk);
        #1;

        out_ready_i = 0;
        send(0, N'($urandom), N'($urandom), N'($urandom));
        repeat (2) @(posedge clk);
        #3 rst_i = 1;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_out", out1_o | out2_o | out3_o, 0);
        @(negedge clk);
        #2 rst_i = 0;
        #1;
        chk("arst_ready", in_ready_o, 1);
        chk("arst_out_rel", out1_o | out2_o | out3_o, 0);
        @(posedge clk);
        #1 out_ready_i = 1;
        repeat (3) @(posedge clk);
        #1 chk("arst_no_ghost", out_valid_o, 0);

        for (int t = 0; t < 800; t++) begin
            in_valid_i  = $urandom_range(0, 3) != 0;
            in_mode_i   = 1'($urandom_range(0, 1));
            in1_i       = N'($urandom);
            in2_i       = N'($urandom);
            in3_i       = N'($urandom);
            out_ready_i = $urandom_range(0, 3) != 0;
            flush_i     = $urandom_range(0, 40) == 0;
            @(posedge clk);
            #1;
        end
        flush_i = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
